console_tx: RTL and testbench

Serial console transmitter for the pipelined CPU: the receiving end of the writeback stage's console-output path, which emits one byte whenever an instruction writes to r0. Bytes are queued in a small FIFO and serialized as 8N1 UART frames, LSB first, on a single output pin. The block sits outside the pipeline and never stalls the core. Bytes that arrive while the FIFO is full are dropped and flagged.

---
 rtl/console_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/console_tx.sv | 174 +++++++++++++++++
 tb/tb_console_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared types and constants for the console serial transmitter.
// Honours CONSOLE_TX_PARITY_EN (even parity bit after the data bits).
package console_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef CONSOLE_TX_PARITY_EN
    StParity,
`endif
    StStop
  } tx_state_e;

  localparam int unsigned DataBits          = 8;
  localparam int unsigned FrameBitsNoParity = 10;
  localparam int unsigned FrameBitsParity   = 11;
`ifdef CONSOLE_TX_PARITY_EN
  localparam int unsigned FrameBits         = FrameBitsParity;
`else
  localparam int unsigned FrameBits         = FrameBitsNoParity;
`endif
  localparam int unsigned DefaultClksPerBit = 434;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read port.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         din,
  output logic [Width-1:0]         dout,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CntW'(Depth));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers are exactly AddrW bits so they wrap at Depth without a compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/console_tx.sv
// Console UART transmitter: byte FIFO feeding an 8N1 serializer, LSB first.
// Defining CONSOLE_TX_PARITY_EN inserts an even parity bit (8E1 framing).
module console_tx
  import console_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

  tx_state_e             r_state;
  tx_state_e             w_state_d;
  logic [BaudW-1:0]      r_baud;
  logic [2:0]            r_bit_idx;
  logic [DataBits-1:0]   r_shift;
  logic                  r_overflow;
  logic                  w_baud_done;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DataBits-1:0]   w_dout;
  logic [CntW-1:0]       w_count;
  logic                  w_tx;
`ifdef CONSOLE_TX_PARITY_EN
  logic                  r_parity;
`endif

  assign w_baud_done = (r_baud == BaudW'(CLKS_PER_BIT - 1));
  assign w_push      = wr_en && !w_full;

  sync_fifo #(
    .Width (DataBits),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (wr_data),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_state_d = StStart;
        end
      end
      StStart: begin
        if (w_baud_done) begin
          w_state_d = StData;
        end
      end
      StData: begin
        if (w_baud_done && (r_bit_idx == 3'd7)) begin
`ifdef CONSOLE_TX_PARITY_EN
          w_state_d = StParity;
`else
          w_state_d = StStop;
`endif
        end
      end
`ifdef CONSOLE_TX_PARITY_EN
      StParity: begin
        if (w_baud_done) begin
          w_state_d = StStop;
        end
      end
`endif
      StStop: begin
        // Chain straight into the next start bit when more bytes are queued.
        if (w_baud_done) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_state_d = StStart;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_tx = 1'b1;
    unique case (r_state)
      StStart:  w_tx = 1'b0;
      StData:   w_tx = r_shift[0];
`ifdef CONSOLE_TX_PARITY_EN
      StParity: w_tx = r_parity;
`endif
      default:  w_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (w_pop || (r_state == StIdle) || w_baud_done) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end

      if (r_state != StData) begin
        r_bit_idx <= '0;
      end else if (w_baud_done) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      if (w_pop) begin
        r_shift <= w_dout;
      end else if ((r_state == StData) && w_baud_done) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

`ifdef CONSOLE_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= ^w_dout;
    end
  end
`endif

  // Drop is decided on the pre-edge full flag, so a same-edge pop does not rescue the byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (wr_en && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign tx       = w_tx;
  assign full     = w_full;
  assign busy     = (r_state != StIdle) || (w_count != '0);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_console_tx.sv
// Directed bench for console_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=16.
// Honours CONSOLE_TX_PARITY_EN to match the DUT build.
module tb_console_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
`ifdef CONSOLE_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx;
  logic       full;
  logic       busy;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  console_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx       (tx),
    .full     (full),
    .busy     (busy),
    .overflow (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Frame bit k: 0 start, 1..8 data LSB first, then parity (if built), then stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if ((FB == 11) && (k == 9)) return ^b;
    return 1'b1;
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] b, input int skip);
    for (int i = skip; i < FB * CPB; i++) begin
      chk($sformatf("%s_%02h_bit%0d", tag, b, i / CPB), tx, frame_bit(b, i / CPB));
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single byte 'A'
    wr_en = 1'b1; wr_data = 8'h41;
    tick();
    wr_en = 1'b0;
    chk("a_tx_idle", tx, 1'b1);
    chk("a_busy_q", busy, 1'b1);
    tick();
    chk("a_start", tx, 1'b0);
    check_frame("a", 8'h41, 0);
    chk("a_busy_done", busy, 1'b0);
    chk("a_tx_done", tx, 1'b1);

    // "Hi" back-to-back
    wr_en = 1'b1; wr_data = 8'h48;
    tick();
    wr_data = 8'h69;
    tick();
    wr_en = 1'b0;
    check_frame("hi", 8'h48, 0);
    check_frame("hi", 8'h69, 0);
    chk("hi_busy_done", busy, 1'b0);

    // 18 consecutive writes: 17 fit (one goes straight to the shifter), the 18th drops
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      tick();
      if (i == 15) chk("fill_full15", full, 1'b0);
      if (i == 16) begin
        chk("fill_full16", full, 1'b1);
        chk("fill_ovf16", overflow, 1'b0);
      end
      if (i == 17) begin
        chk("fill_full17", full, 1'b1);
        chk("fill_ovf17", overflow, 1'b1);
      end
    end
    wr_en = 1'b0;
    check_frame("fill", 8'h30, 16);
    for (int i = 1; i < 17; i++) check_frame("fill", 8'h30 + 8'(i), 0);
    chk("fill_busy_done", busy, 1'b0);
    chk("fill_ovf_sticky", overflow, 1'b1);
    chk("fill_full_done", full, 1'b0);

    // Write while full on the edge that ends a stop bit
    do_reset();
    chk("pop_ovf_clr", overflow, 1'b0);
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'h80 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("pop_full", full, 1'b1);
    for (int i = 15; i < FB * CPB - 1; i++) begin
      chk($sformatf("pop_80_bit%0d", i / CPB), tx, frame_bit(8'h80, i / CPB));
      tick();
    end
    chk("pop_stop_last", tx, 1'b1);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    chk("pop_ovf", overflow, 1'b1);
    chk("pop_full_clr", full, 1'b0);
    wr_data = 8'hC3;
    tick();
    wr_en = 1'b0;
    chk("pop_refill_full", full, 1'b1);
    check_frame("pop", 8'h81, 1);
    for (int i = 2; i < 17; i++) check_frame("pop", 8'h80 + 8'(i), 0);
    check_frame("pop", 8'hC3, 0);
    chk("pop_busy_done", busy, 1'b0);

    // Reset in the middle of data bit 3 of 0x55 with 0xAA queued
    wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    repeat (17) tick();
    chk("mid_bit3", tx, 1'b0);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_full", full, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i % 5 == 0) begin
        chk("post_rst_tx", tx, 1'b1);
        chk("post_rst_busy", busy, 1'b0);
      end
    end

`ifdef CONSOLE_TX_PARITY_EN
    wr_en = 1'b1; wr_data = 8'h07;
    tick();
    wr_data = 8'h03;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 9 * CPB; i++) tick();
    chk("par07_bit", tx, 1'b1);
    check_frame("par", 8'h07, 9 * CPB);
    for (int i = 0; i < 9 * CPB; i++) tick();
    chk("par03_bit", tx, 1'b0);
    check_frame("par", 8'h03, 9 * CPB);
    chk("par_busy_done", busy, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
